// File: rtl/display_scanout_if.sv
// Framebuffer read bus between the scanout engine (master) and the external pixel RAM (slave).
// The RAM returns fb_data a fixed number of cycles after it samples fb_addr.
interface display_scanout_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int PIXEL_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0]  fb_addr;
  logic [PIXEL_WIDTH-1:0] fb_data;

  modport master (output fb_addr, input fb_data);
  modport slave  (input fb_addr, output fb_data);
endinterface

// File: rtl/display_scanout.sv
// VGA scanout: timing generator, scaled multi-page framebuffer walk, palette lookup and vblank page flip.
// Optional SCANOUT_TEST_PATTERN_EN adds a test_mode input that replaces fb_data with an fb_x^fb_y pattern.
module display_scanout #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FP             = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BP             = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FP             = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BP             = 33,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0,
  parameter int FB_WIDTH         = 160,
  parameter int FB_HEIGHT        = 120,
  parameter int SCALE_X          = 4,
  parameter int SCALE_Y          = 4,
  parameter int FB_X0            = 0,
  parameter int FB_Y0            = 0,
  parameter int NUM_PAGES        = 2,
  parameter int PIXEL_WIDTH      = 4,
  parameter int CHANNEL_WIDTH    = 4,
  parameter int MEM_LATENCY      = 1,
  localparam int FB_DEPTH        = FB_WIDTH * FB_HEIGHT,
  localparam int ADDR_WIDTH      = ($clog2(FB_DEPTH * NUM_PAGES) > 1) ? $clog2(FB_DEPTH * NUM_PAGES) : 1,
  localparam int PAGE_WIDTH      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                       clk_pix,
  input  logic                       rst_pix,
  display_scanout_if.master          fb,
  input  logic                       pal_we,
  input  logic [PIXEL_WIDTH-1:0]     pal_addr,
  input  logic [3*CHANNEL_WIDTH-1:0] pal_data,
  input  logic [3*CHANNEL_WIDTH-1:0] border_color,
  input  logic [PAGE_WIDTH-1:0]      swap_page,
  input  logic                       swap_req,
  output logic                       swap_ack,
  output logic [PAGE_WIDTH-1:0]      disp_page,
  output logic [CHANNEL_WIDTH-1:0]   o_red,
  output logic [CHANNEL_WIDTH-1:0]   o_green,
  output logic [CHANNEL_WIDTH-1:0]   o_blue,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       de,
  output logic                       frame
`ifdef SCANOUT_TEST_PATTERN_EN
  ,
  input  logic                       test_mode
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int X_END    = FB_X0 + FB_WIDTH * SCALE_X;
  localparam int Y_END    = FB_Y0 + FB_HEIGHT * SCALE_Y;
  localparam int XSW      = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int YSW      = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
  localparam int DLY      = MEM_LATENCY + 2;
  localparam int CW3      = 3 * CHANNEL_WIDTH;
  localparam logic SYNC_IDLE = ~SYNC_ACTIVE_HIGH;

  function automatic logic [2**PAGE_WIDTH-1:0] page_valid_mask();
    logic [2**PAGE_WIDTH-1:0] m;
    for (int i = 0; i < 2**PAGE_WIDTH; i++) m[i] = (i < NUM_PAGES);
    return m;
  endfunction

  localparam logic [2**PAGE_WIDTH-1:0] PAGE_VALID = page_valid_mask();

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic in_fb;
  } ctl_t;

  logic [HW-1:0]          sx;
  logic [VW-1:0]          sy;
  logic                   active, hs_now, vs_now, col_in_win, row_in_win, in_fb;
  logic                   line_end, frame_end, flip_now, swap_valid;
  logic [XSW-1:0]         x_sub;
  logic [YSW-1:0]         y_sub;
  logic [ADDR_WIDTH-1:0]  fb_x, line_base, page_base, fb_addr_q, next_base;
  logic                   flip_pend;
  logic [PAGE_WIDTH-1:0]  pend_page, next_page;
  ctl_t                   ctl_now, ctl_out;
  ctl_t                   ctl_d [DLY];
  logic [CW3-1:0]         palette [2**PIXEL_WIDTH];
  logic [CW3-1:0]         pal_q;
  logic [PIXEL_WIDTH-1:0] pal_idx;

  // Raster position decode; everything downstream is relative to the counter state.
  assign active     = (int'(sx) < H_ACTIVE) && (int'(sy) < V_ACTIVE);
  assign hs_now     = (int'(sx) >= HS_START) && (int'(sx) < HS_END);
  assign vs_now     = (int'(sy) >= VS_START) && (int'(sy) < VS_END);
  assign col_in_win = (int'(sx) >= FB_X0) && (int'(sx) < X_END);
  assign row_in_win = (int'(sy) >= FB_Y0) && (int'(sy) < Y_END) && (int'(sy) < V_ACTIVE);
  assign in_fb      = active && col_in_win && row_in_win;
  assign line_end   = (sx == HW'(H_TOTAL - 1));
  assign frame_end  = line_end && (sy == VW'(V_TOTAL - 1));
  assign flip_now   = (sx == '0) && (sy == VW'(V_ACTIVE));
  assign frame      = !rst_pix && (sx == '0) && (sy == '0);
  assign fb.fb_addr = fb_addr_q;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sx <= '0;
      sy <= '0;
    end else if (line_end) begin
      sx <= '0;
      sy <= (sy == VW'(V_TOTAL - 1)) ? '0 : sy + VW'(1);
    end else begin
      sx <= sx + HW'(1);
    end
  end

  // Incremental address walk: the sub-counters describe the pixel at the current sx/sy.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      x_sub     <= '0;
      fb_x      <= '0;
      y_sub     <= '0;
      line_base <= '0;
      fb_addr_q <= '0;
    end else begin
      if (in_fb) begin
        fb_addr_q <= page_base + line_base + fb_x;
        if (x_sub == XSW'(SCALE_X - 1)) begin
          x_sub <= '0;
          fb_x  <= fb_x + ADDR_WIDTH'(1);
        end else begin
          x_sub <= x_sub + XSW'(1);
        end
      end else begin
        x_sub <= '0;
        fb_x  <= '0;
      end
      if (frame_end) begin
        y_sub     <= '0;
        line_base <= '0;
      end else if (line_end && row_in_win) begin
        if (y_sub == YSW'(SCALE_Y - 1)) begin
          y_sub     <= '0;
          line_base <= line_base + ADDR_WIDTH'(FB_WIDTH);
        end else begin
          y_sub <= y_sub + YSW'(1);
        end
      end
    end
  end

  assign swap_valid = swap_req && PAGE_VALID[swap_page];
  assign next_page  = swap_valid ? swap_page : pend_page;

  // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    next_base = '0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (next_page == PAGE_WIDTH'(p)) next_base = ADDR_WIDTH'(p * FB_DEPTH);
    end
  end

  // A request on the flip cycle itself wins over the pending page.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      flip_pend <= 1'b0;
      pend_page <= '0;
      disp_page <= '0;
      page_base <= '0;
      swap_ack  <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (flip_now && (flip_pend || swap_valid)) begin
        disp_page <= next_page;
        page_base <= next_base;
        swap_ack  <= 1'b1;
        flip_pend <= 1'b0;
      end else if (swap_valid) begin
        pend_page <= swap_page;
        flip_pend <= 1'b1;
      end
    end
  end

  assign ctl_now = '{hs: hs_now, vs: vs_now, de: active, in_fb: in_fb};
  assign ctl_out = ctl_d[DLY-1];

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      for (int i = 0; i < DLY; i++) ctl_d[i] <= '0;
    end else begin
      ctl_d[0] <= ctl_now;
      for (int i = 1; i < DLY; i++) ctl_d[i] <= ctl_d[i-1];
    end
  end

`ifdef SCANOUT_TEST_PATTERN_EN
  logic                   test_mode_q;
  logic [ADDR_WIDTH-1:0]  fb_y;
  logic [PIXEL_WIDTH-1:0] tp_d [MEM_LATENCY+1];

  // Pattern index travels beside fb_addr and the RAM latency so it meets the palette stage aligned.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      test_mode_q <= 1'b0;
      fb_y        <= '0;
      for (int i = 0; i <= MEM_LATENCY; i++) tp_d[i] <= '0;
    end else begin
      if (frame) test_mode_q <= test_mode;
      if (frame_end) fb_y <= '0;
      else if (line_end && row_in_win && (y_sub == YSW'(SCALE_Y - 1))) fb_y <= fb_y + ADDR_WIDTH'(1);
      if (in_fb) tp_d[0] <= PIXEL_WIDTH'(fb_x ^ fb_y);
      for (int i = 1; i <= MEM_LATENCY; i++) tp_d[i] <= tp_d[i-1];
    end
  end

  assign pal_idx = test_mode_q ? tp_d[MEM_LATENCY] : fb.fb_data;
`else
  assign pal_idx = fb.fb_data;
`endif

  // NOTE: the palette RAM and its read register are deliberately not reset so they map onto RAM;
  // a same-cycle write to the entry being read returns the old contents.
  always_ff @(posedge clk_pix) begin
    if (pal_we) palette[pal_addr] <= pal_data;
    pal_q <= palette[pal_idx];
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      {o_red, o_green, o_blue} <= '0;
      de    <= 1'b0;
      hsync <= SYNC_IDLE;
      vsync <= SYNC_IDLE;
    end else begin
      de    <= ctl_out.de;
      hsync <= ctl_out.hs ^ SYNC_IDLE;
      vsync <= ctl_out.vs ^ SYNC_IDLE;
      if (!ctl_out.de)        {o_red, o_green, o_blue} <= '0;
      else if (ctl_out.in_fb) {o_red, o_green, o_blue} <= pal_q;
      else                    {o_red, o_green, o_blue} <= border_color;
    end
  end

endmodule

// File: doc/display_scanout.md
Name: display_scanout

Overview:
- Parametrised scanout engine: generates the video timing, walks a multi-page indexed framebuffer with independent X/Y integer scaling and a placement offset, and colour-maps pixels through an internal writable palette.
- Sits between the framebuffer read port (external RAM, fixed read latency) and the VGA pins.
- Page flipping is synchronised to vertical blank, so the rasteriser can draw into a back page.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths
- SYNC_ACTIVE_HIGH, 0, polarity of hsync/vsync; 0 = active-low
- FB_WIDTH / FB_HEIGHT, 160 / 120, framebuffer dimensions in pixels
- SCALE_X / SCALE_Y, 4 / 4, screen pixels per fb pixel; each ≥1
- FB_X0 / FB_Y0, 0 / 0, screen position of the fb top-left pixel
- NUM_PAGES, 2, framebuffer pages; ≥1
- PIXEL_WIDTH, 4, palette index width
- CHANNEL_WIDTH, 4, bits per colour channel
- MEM_LATENCY, 1, cycles from fb_addr to fb_data; ≥1
- Derived:
  - FB_DEPTH = FB_WIDTH*FB_HEIGHT
  - ADDR_WIDTH = $clog2(FB_DEPTH*NUM_PAGES)
  - PAGE_WIDTH = max(1, $clog2(NUM_PAGES))
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise

Ports:
- clk_pix  in  1  pixel clock; the only clock
- rst_pix  in  1  synchronous, active-high reset
- fb_addr  out  ADDR_WIDTH  framebuffer read address
- fb_data  in  PIXEL_WIDTH  read data, valid MEM_LATENCY cycles after fb_addr
- pal_we  in  1  palette write strobe
- pal_addr  in  PIXEL_WIDTH  palette entry to write
- pal_data  in  3*CHANNEL_WIDTH  {R,G,B}
- border_color  in  3*CHANNEL_WIDTH  colour shown in the active area outside the fb window
- swap_page  in  PAGE_WIDTH  page to display next
- swap_req  in  1  one-cycle request to flip to swap_page
- swap_ack  out  1  one-cycle pulse when the flip takes effect
- disp_page  out  PAGE_WIDTH  page currently displayed
- o_red / o_green / o_blue  out  CHANNEL_WIDTH each  colour outputs
- hsync / vsync  out  1  sync outputs, polarity per SYNC_ACTIVE_HIGH
- de  out  1  data enable, aligned with colour
- frame  out  1  one-cycle pulse at sx=0, sy=0, before pipeline delay

Behaviour:
- Timing counters:
  - sx runs 0..H_TOTAL-1; sy increments when sx wraps and itself wraps at V_TOTAL.
  - Active region: sx<H_ACTIVE and sy<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP ≤ sx < H_ACTIVE+H_FP+H_SYNC; vsync likewise on sy.
- Window: in_fb = active, FB_X0 ≤ sx < FB_X0+FB_WIDTH*SCALE_X, and FB_Y0 ≤ sy < FB_Y0+FB_HEIGHT*SCALE_Y. Any part of the window beyond the active area is clipped.
- Address generation is incremental; no multipliers. Registers:
  - x_sub (0..SCALE_X-1), fb_x
  - y_sub (0..SCALE_Y-1), line_base
  - page_base = disp_page*FB_DEPTH, updated only on flip
- Horizontal walk:
  - x_sub and fb_x reset at the start of each window line.
  - fb_x advances when x_sub wraps.
- Vertical walk:
  - At the end of each window line, y_sub advances.
  - On y_sub wrap, line_base += FB_WIDTH.
  - line_base and y_sub reset at frame start.
- fb_addr = page_base+line_base+fb_x, registered.
- Outside the window, fb_addr holds its last value.
- Pipeline, total latency PIPE = MEM_LATENCY+3 from counter state to pins:
  - address register (1 cycle)
  - memory (MEM_LATENCY cycles)
  - palette read register (1 cycle)
  - output register (1 cycle)
- hsync, vsync, de and in_fb go through a matching PIPE-deep delay line, so colour and syncs stay aligned.
- Output colour (registered):
  - de=0 → 0
  - de=1 and in_fb → palette[fb_data]
  - de=1, outside window → border_color
- Palette:
  - 2^PIXEL_WIDTH entries, one write port, one read port; not reset.
  - A write to the entry being read this cycle returns the old value.
- Page flip:
  - swap_req latches swap_page into pending and sets flip_pend.
  - A second request before the flip overwrites pending; only one ack is produced.
  - The flip occurs on the cycle sx=0, sy=V_ACTIVE (first blank line): disp_page and page_base update and swap_ack pulses.
  - If swap_req arrives on that same cycle, the new value is used.
  - swap_page ≥ NUM_PAGES is ignored (no pend, no ack).
- Reset, synchronous:
  - sx=sy=0, all sub-counters and bases 0, disp_page=0, flip_pend=0.
  - Delay-line contents cleared: de=0, colour 0, syncs inactive level, swap_ack=0.
  - frame=0 during reset; it pulses on the first cycle after release.
  - Reset mid-frame discards any pending flip.

Optional Feature:
- Macro: SCANOUT_TEST_PATTERN_EN.
- When defined:
  - Adds input port test_mode (1 bit).
  - While test_mode=1, the palette index fed to the palette stage is (fb_x ^ line counter)[PIXEL_WIDTH-1:0] instead of fb_data. Timing, border handling and latency are unchanged.
  - test_mode changes take effect on the next frame pulse.
- When undefined: port absent, fb_data always used.

Test Plan:
- Timing, defaults: reset then run 1 frame → hsync low exactly 96 cycles per line starting at sx=656; vsync low on lines 490–491; 800×525 cycles between frame pulses.
- Scaling/addressing: FB 4×2, SCALE_X=2, SCALE_Y=3, MEM_LATENCY=1, distinct palette per index, fb[i]=i. Required fb_addr sequence:
  - per line: 0,0,1,1,2,2,3,3
  - lines 0–2 use base 0; lines 3–5 use base 4
  - colours appear PIPE=4 cycles after the matching address, aligned with de.
- Border: FB_X0=10, FB_Y0=5, border_color=12'hF00 → pixel (9,5) is F00; (10,5) is palette[fb[0]]; (9,4) is F00; blanking is 000.
- Page flip: NUM_PAGES=2, swap_page=1 and swap_req mid-frame → disp_page stays 0 until sx=0, sy=480. swap_ack pulses once there. Next frame fb_addr starts at FB_DEPTH=19200.
- Edge requests:
  - swap_page=3 with NUM_PAGES=2 → no ack.
  - Two requests (1 then 0) in one frame → a single ack, disp_page=0.
  - Reset asserted with a flip pending → no ack after release.
- Palette hazard: write palette[3]=0x0F0 while index 3 is being read → that pixel shows the old value; the following one shows 0x0F0.
